// File: rtl/mem_bus_arbiter.sv
// Two-port to one-master memory bus arbiter for the OpenMIPS SOPC.
// Data port has priority; a streak counter forces a fetch grant to bound fetch starvation.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                m_cyc,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_sel,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                stall_req,
    output logic                err
);
    localparam int SEL_W  = DATA_W / 8;
    // wait_cnt never has to hold MAX_WAIT itself: the abort fires as it would reach it
    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(MAX_WAIT - 1);
    localparam logic [SCNT_W-1:0] STREAK_MAX = SCNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    typedef struct packed {
        logic              cyc;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    state_t            state, state_nxt;
    bus_req_t          bus, bus_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_nxt;
    logic [SCNT_W-1:0] d_streak, streak_nxt;
    logic              i_ack_nxt, d_ack_nxt, err_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
    logic              grant_d, grant_i, done;

    assign grant_d = d_req & (~i_req | (d_streak != STREAK_MAX));
    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_nxt   = state;
        bus_nxt     = bus;
        wait_nxt    = wait_cnt;
        streak_nxt  = d_streak;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        err_nxt     = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = BUSY_D;
                    bus_nxt.cyc   = 1'b1;
                    bus_nxt.we    = d_we;
                    bus_nxt.sel   = d_sel;
                    bus_nxt.addr  = d_addr;
                    bus_nxt.wdata = d_wdata;
                    wait_nxt      = '0;
                    if (!i_req)
                        streak_nxt = '0;
                    else if (d_streak != STREAK_MAX)
                        streak_nxt = d_streak + 1'b1;
                end else if (grant_i) begin
                    state_nxt     = BUSY_I;
                    bus_nxt.cyc   = 1'b1;
                    bus_nxt.we    = 1'b0;
                    bus_nxt.sel   = '1;
                    bus_nxt.addr  = i_addr;
                    bus_nxt.wdata = '0;
                    wait_nxt      = '0;
                    streak_nxt    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // a late m_ack on the abort edge still wins over the timeout
                done = m_ack | (wait_cnt == WAIT_LAST);
                if (done) begin
                    state_nxt = IDLE;
                    bus_nxt   = '0;
                    wait_nxt  = '0;
                    err_nxt   = ~m_ack;
                    if (state == BUSY_I) begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = m_ack ? m_rdata : '0;
                    end else begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = m_ack ? m_rdata : '0;
                    end
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                bus_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bus      <= '0;
            wait_cnt <= '0;
            d_streak <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            bus      <= bus_nxt;
            wait_cnt <= wait_nxt;
            d_streak <= streak_nxt;
            i_ack    <= i_ack_nxt;
            d_ack    <= d_ack_nxt;
            err      <= err_nxt;
            i_rdata  <= i_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
        end
    end

    assign m_cyc     = bus.cyc;
    assign m_we      = bus.we;
    assign m_sel     = bus.sel;
    assign m_addr    = bus.addr;
    assign m_wdata   = bus.wdata;
    assign stall_req = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int MAX_WAIT = 15;
    localparam int STARVE   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel, m_sel;
    logic        m_cyc, m_we, m_ack, stall_req, err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall_req(stall_req), .err(err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ir, ia, dr, dw, ds, da, dd, ma, md;
        logic [31:0] cyc, we, sel, addr, wdata, iack, ird, dack, drd, er, stall;
    } vec_t;

    vec_t tbl[12];

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_cyc"}, m_cyc, 1'b0);
        chk1({tag, "_we"}, m_we, 1'b0);
        chk32({tag, "_sel"}, 32'(m_sel), 0);
        chk32({tag, "_addr"}, m_addr, 0);
        chk32({tag, "_wdata"}, m_wdata, 0);
        chk1({tag, "_iack"}, i_ack, 1'b0);
        chk1({tag, "_dack"}, d_ack, 1'b0);
        chk32({tag, "_irdata"}, i_rdata, 0);
        chk32({tag, "_drdata"}, d_rdata, 0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // reference model state (random phase)
    int          act, age;
    bit          dead, starved, gd;
    bit          glog[$];
    logic        e_cyc, e_we, e_iack, e_dack, e_err;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;

    initial begin
        int got[$];
        int exp_pat[6];
        int n;
        bit done;

        //         ir  ia        dr dw ds   da    dd           ma md            cyc we sel  addr   wdata        iack ird           dack drd   er stall
        tbl[0]  = '{1, 'h100,    0, 0, 0,   0,    0,           0, 0,            1,  0, 'hF, 'h100, 0,           0, 0,             0, 0,     0, 1};
        tbl[1]  = '{1, 'h100,    0, 0, 0,   0,    0,           1, 'h3C010001,   0,  0, 0,   0,     0,           1, 'h3C010001,    0, 0,     0, 0};
        tbl[2]  = '{0, 0,        0, 0, 0,   0,    0,           0, 0,            0,  0, 0,   0,     0,           0, 'h3C010001,    0, 0,     0, 0};
        tbl[3]  = '{1, 'h200,    1, 1, 'hF, 'h20, 'hDEADBEEF,  0, 0,            1,  1, 'hF, 'h20,  'hDEADBEEF,  0, 'h3C010001,    0, 0,     0, 1};
        tbl[4]  = '{1, 'h200,    1, 1, 'hF, 'h20, 'hDEADBEEF,  1, 'h11,         0,  0, 0,   0,     0,           0, 'h3C010001,    1, 'h11,  0, 1};
        tbl[5]  = '{1, 'h200,    0, 0, 0,   0,    0,           0, 0,            1,  0, 'hF, 'h200, 0,           0, 'h3C010001,    0, 'h11,  0, 1};
        tbl[6]  = '{1, 'h200,    0, 0, 0,   0,    0,           1, 'h22,         0,  0, 0,   0,     0,           1, 'h22,          0, 'h11,  0, 0};
        tbl[7]  = '{0, 0,        0, 0, 0,   0,    0,           0, 0,            0,  0, 0,   0,     0,           0, 'h22,          0, 'h11,  0, 0};
        tbl[8]  = '{0, 0,        0, 0, 0,   0,    0,           1, 'h99,         0,  0, 0,   0,     0,           0, 'h22,          0, 'h11,  0, 0};
        tbl[9]  = '{1, 'h300,    0, 0, 0,   0,    0,           1, 'h55,         1,  0, 'hF, 'h300, 0,           0, 'h22,          0, 'h11,  0, 1};
        tbl[10] = '{1, 'h300,    0, 0, 0,   0,    0,           1, 'h33,         0,  0, 0,   0,     0,           1, 'h33,          0, 'h11,  0, 0};
        tbl[11] = '{0, 0,        0, 0, 0,   0,    0,           0, 0,            0,  0, 0,   0,     0,           0, 'h33,          0, 'h11,  0, 0};

        idle_in();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk1("reset_stall", stall_req, 1'b0);
        reset = 1'b1;

        // directed table: inputs for one cycle, outputs checked after that edge
        for (int r = 0; r < 12; r++) begin
            i_req = tbl[r].ir[0]; i_addr = tbl[r].ia;
            d_req = tbl[r].dr[0]; d_we = tbl[r].dw[0]; d_sel = tbl[r].ds[3:0];
            d_addr = tbl[r].da; d_wdata = tbl[r].dd;
            m_ack = tbl[r].ma[0]; m_rdata = tbl[r].md;
            @(negedge clk);
            chk1($sformatf("tbl%0d_cyc", r), m_cyc, tbl[r].cyc[0]);
            chk1($sformatf("tbl%0d_we", r), m_we, tbl[r].we[0]);
            chk32($sformatf("tbl%0d_sel", r), 32'(m_sel), tbl[r].sel);
            chk32($sformatf("tbl%0d_addr", r), m_addr, tbl[r].addr);
            chk32($sformatf("tbl%0d_wdata", r), m_wdata, tbl[r].wdata);
            chk1($sformatf("tbl%0d_iack", r), i_ack, tbl[r].iack[0]);
            chk32($sformatf("tbl%0d_irdata", r), i_rdata, tbl[r].ird);
            chk1($sformatf("tbl%0d_dack", r), d_ack, tbl[r].dack[0]);
            chk32($sformatf("tbl%0d_drdata", r), d_rdata, tbl[r].drd);
            chk1($sformatf("tbl%0d_err", r), err, tbl[r].er[0]);
            chk1($sformatf("tbl%0d_stall", r), stall_req, tbl[r].stall[0]);
        end

        // starvation guard: both held, slave acks on first bus cycle
        idle_in();
        i_req = 1'b1; i_addr = 'h400;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 'h40;
        for (int c = 0; c < 80 && got.size() < 6; c++) begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_cyc) begin
                got.push_back(m_addr == 'h40 ? 2 : 1);
                m_ack = 1'b1;
                m_rdata = 'h1000 + c;
            end
        end
        @(negedge clk);
        idle_in();
        @(negedge clk);
        exp_pat = '{2, 2, 2, 2, 1, 2};
        chk32("starve_grant_count", got.size(), 6);
        for (int k = 0; k < 6; k++)
            chk32($sformatf("starve_grant%0d", k), (k < got.size()) ? got[k] : 0, exp_pat[k]);

        // timeout: load never acknowledged
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 'h80; m_rdata = 'hABCD;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (m_cyc) n++;
            if (d_ack) begin
                done = 1'b1;
                chk32("timeout_cycles", n, MAX_WAIT);
                chk32("timeout_drdata", d_rdata, 0);
                chk1("timeout_err", err, 1'b1);
                chk1("timeout_cyc_low", m_cyc, 1'b0);
                chk1("timeout_no_iack", i_ack, 1'b0);
            end else begin
                chk1("timeout_err_early", err, 1'b0);
            end
        end
        if (!done) chk1("timeout_ack_seen", 1'b0, 1'b1);
        idle_in();
        @(negedge clk);
        chk1("timeout_err_single", err, 1'b0);
        chk1("timeout_dack_single", d_ack, 1'b0);
        i_req = 1'b1; i_addr = 'h500;
        @(negedge clk);
        chk1("post_to_cyc", m_cyc, 1'b1);
        chk32("post_to_addr", m_addr, 'h500);
        m_ack = 1'b1; m_rdata = 'h77;
        @(negedge clk);
        chk1("post_to_iack", i_ack, 1'b1);
        chk32("post_to_irdata", i_rdata, 'h77);
        idle_in();
        @(negedge clk);

        // asynchronous reset in the middle of a fetch
        i_req = 1'b1; i_addr = 'h600;
        @(negedge clk);
        chk1("rst_mid_cyc_before", m_cyc, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle_in();
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        reset = 1'b1;
        m_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("stray_ack_iack", i_ack, 1'b0);
            chk1("stray_ack_dack", d_ack, 1'b0);
            chk1("stray_ack_cyc", m_cyc, 1'b0);
        end
        idle_in();

        // random traffic against the reference model
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("rand_reset");
        reset = 1'b1;
        act = 0; age = 0; dead = 1'b0; glog.delete();
        e_cyc = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0;
        e_iack = 0; e_dack = 0; e_err = 0; e_ird = '0; e_drd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk1("rnd_cyc", m_cyc, e_cyc);
            chk1("rnd_we", m_we, e_we);
            chk32("rnd_sel", 32'(m_sel), 32'(e_sel));
            chk32("rnd_addr", m_addr, e_addr);
            chk32("rnd_wdata", m_wdata, e_wdata);
            chk1("rnd_iack", i_ack, e_iack);
            chk32("rnd_irdata", i_rdata, e_ird);
            chk1("rnd_dack", d_ack, e_dack);
            chk32("rnd_drdata", d_rdata, e_drd);
            chk1("rnd_err", err, e_err);
            chk1("rnd_stall", stall_req, (i_req & ~e_iack) | (d_req & ~e_dack));
            chk1("rnd_ack_excl", i_ack & d_ack, 1'b0);

            // requesters hold until acked, then may re-request at once
            if (!i_req || e_iack) begin
                i_req = ($urandom % 2) == 0;
                i_addr = $urandom;
            end
            if (!d_req || e_dack) begin
                d_req = ($urandom % 2) == 0;
                d_we = 1'($urandom);
                d_sel = 4'($urandom);
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            m_rdata = $urandom;
            m_ack = e_cyc ? (!dead && ($urandom % 3) == 0) : (($urandom % 4) == 0);

            e_iack = 1'b0; e_dack = 1'b0; e_err = 1'b0;
            if (act == 0) begin
                if (i_req || d_req) begin
                    starved = (glog.size() == STARVE);
                    foreach (glog[k]) if (!glog[k]) starved = 1'b0;
                    gd = d_req && !(i_req && starved);
                    glog.push_back(gd && i_req);
                    if (glog.size() > STARVE) void'(glog.pop_front());
                    act = gd ? 2 : 1;
                    age = 0;
                    dead = ($urandom % 10) == 0;
                    e_cyc = 1'b1;
                    e_we = gd ? d_we : 1'b0;
                    e_sel = gd ? d_sel : 4'hF;
                    e_addr = gd ? d_addr : i_addr;
                    e_wdata = gd ? d_wdata : '0;
                end
            end else begin
                age++;
                if (m_ack || age == MAX_WAIT) begin
                    if (act == 1) begin
                        e_iack = 1'b1;
                        e_ird = m_ack ? m_rdata : '0;
                    end else begin
                        e_dack = 1'b1;
                        e_drd = m_ack ? m_rdata : '0;
                    end
                    e_err = !m_ack;
                    act = 0;
                    e_cyc = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
